// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: state/mode codes and helpers.
// Benches import this package so that they use the same encodings as the RTL.
package pipeline_run_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PRST = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_THROTTLE = 2'b01;
  localparam logic [1:0] MODE_STEP     = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PRST = ST_PRST,
    S_RUN  = ST_RUN,
    S_HALT = ST_HALT
  } state_e;

  // The reserved mode code behaves exactly like RUN.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_RUN : m;
  endfunction

endpackage

// File: rtl/pipeline_throttle_gen.sv
// Throttle phase generator: strobes once every div_i+1 enabled cycles, starting at phase 0.
// clr_i restarts the phase so that the current cycle is treated as phase 0.
module pipeline_throttle_gen #(
  parameter int NB = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [NB-1:0] div_i,
  output logic          strobe_o
);

  logic [NB-1:0] phase_q, phase_d, cur;

  always_comb begin
    cur      = clr_i ? '0 : phase_q;
    strobe_o = en_i && (cur == '0);
    phase_d  = '0;
    if (en_i) phase_d = (cur >= div_i) ? '0 : cur + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for a pipeline under test: reset pulse, RUN/THROTTLE/STEP valid
// generation, valid-cycle counting, and halt on request or on a cycle limit.
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int NB_COUNT     = 32,
  parameter int RESET_CYCLES = 2,
  parameter int NB_THROTTLE  = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [1:0]             i_mode,
  input  logic [NB_THROTTLE-1:0] i_throttle,
  input  logic                   i_step,
  input  logic                   i_halt,
  input  logic [NB_COUNT-1:0]    i_max_cycles,
  output logic                   o_pipe_reset,
  output logic                   o_pipe_valid,
  output logic [NB_COUNT-1:0]    o_cycle_count,
  output logic [1:0]             o_state,
  output logic                   o_done
);

  state_e                 state_q;
  logic                   pipe_reset_q, pipe_valid_q, done_q, step_prev_q;
  logic [NB_COUNT-1:0]    cnt_q, cnt_d;
  logic [7:0]             prst_cnt_q;
  logic [1:0]             mode_q;
  logic [NB_THROTTLE-1:0] thr_q, tg_div;
  logic                   enter_run, halt_now, step_rise, tg_en, tg_clr, tg_strobe, run_valid;

  always_comb begin
    cnt_d     = (pipe_valid_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    enter_run = (state_q == S_PRST) && (prst_cnt_q == '0);
    // The valid cycle that reaches the limit is counted before halting.
    halt_now  = (state_q == S_RUN) &&
                (i_halt || (pipe_valid_q && (i_max_cycles != '0) && (cnt_d >= i_max_cycles)));
    step_rise = i_step && !step_prev_q;
    tg_en     = enter_run || ((state_q == S_RUN) && !halt_now);
    tg_clr    = enter_run || (i_mode != mode_q) || (i_throttle != thr_q);
    tg_div    = (eff_mode(i_mode) == MODE_THROTTLE) ? i_throttle : '0;
    run_valid = (eff_mode(i_mode) == MODE_STEP) ? step_rise : tg_strobe;
  end

  pipeline_throttle_gen #(.NB(NB_THROTTLE)) u_throttle (
    .clk_i    (i_clock),
    .rst_i    (i_reset),
    .en_i     (tg_en),
    .clr_i    (tg_clr),
    .div_i    (tg_div),
    .strobe_o (tg_strobe)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      pipe_reset_q <= 1'b0;
      pipe_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      prst_cnt_q   <= '0;
      step_prev_q  <= 1'b0;
      mode_q       <= '0;
      thr_q        <= '0;
    end else begin
      step_prev_q <= i_step;
      mode_q      <= i_mode;
      thr_q       <= i_throttle;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            state_q      <= S_PRST;
            pipe_reset_q <= 1'b1;
            pipe_valid_q <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            prst_cnt_q   <= 8'(RESET_CYCLES - 1);
          end
        end
        S_PRST: begin
          if (enter_run) begin
            state_q      <= S_RUN;
            pipe_reset_q <= 1'b0;
            pipe_valid_q <= run_valid;
          end else begin
            prst_cnt_q <= prst_cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_d;
          if (halt_now) begin
            state_q      <= S_HALT;
            pipe_valid_q <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            pipe_valid_q <= run_valid;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_pipe_reset  = pipe_reset_q;
  assign o_pipe_valid  = pipe_valid_q;
  assign o_cycle_count = cnt_q;
  assign o_state       = state_q;
  assign o_done        = done_q;

endmodule

// File: doc/pipeline_run_ctrl.md
PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 Parameter NB_COUNT, default 32, SHALL set the width of the cycle counter and cycle limit.
REQ-002 Parameter RESET_CYCLES, default 2, SHALL set the number of cycles o_pipe_reset is held (legal range 1..255).
REQ-003 Parameter NB_THROTTLE, default 4, SHALL set the width of the throttle divisor.
REQ-004 Ports SHALL be:
  i_clock       in   1            single clock, all state on rising edge
  i_reset       in   1            asynchronous, active-high reset
  i_start       in   1            level, sampled per cycle; launches a run from IDLE or HALT
  i_mode        in   2            00 RUN, 01 THROTTLE, 10 STEP, 11 treated as RUN
  i_throttle    in   NB_THROTTLE  THROTTLE mode: valid once every i_throttle+1 cycles
  i_step        in   1            STEP mode: rising edge requests one valid cycle
  i_halt        in   1            halt request from the pipeline (e.g. halt opcode retired)
  i_max_cycles  in   NB_COUNT     auto-halt limit on valid cycles; 0 disables
  o_pipe_reset  out  1            reset to the pipeline under control
  o_pipe_valid  out  1            throughput/valid to the pipeline
  o_cycle_count out  NB_COUNT     number of valid cycles issued in the current run
  o_state       out  2            00 IDLE, 01 PRST, 10 RUN, 11 HALT
  o_done        out  1            high while in HALT

Function
REQ-005 All outputs SHALL be registered; no combinational input-to-output path.
REQ-006 IDLE: o_pipe_reset=0, o_pipe_valid=0; i_start=1 SHALL move to PRST on the next edge.
REQ-007 PRST: o_pipe_reset=1 for exactly RESET_CYCLES consecutive cycles, o_pipe_valid=0, o_cycle_count cleared to 0; then RUN.
REQ-008 Latency: i_start sampled at edge n SHALL give o_pipe_reset high in cycles n+1..n+RESET_CYCLES and, in RUN mode, first o_pipe_valid=1 in cycle n+RESET_CYCLES+1.
REQ-009 RUN, mode RUN: o_pipe_valid=1 every cycle.
REQ-010 RUN, mode THROTTLE: a phase counter SHALL count 0..i_throttle and wrap; o_pipe_valid=1 only at phase 0; i_throttle=0 SHALL equal mode RUN.
REQ-011 Phase counter SHALL reset to 0 on entry to RUN and on any i_mode or i_throttle change; new setting takes effect on the next cycle.
REQ-012 RUN, mode STEP: each 0->1 transition of i_step SHALL produce exactly one o_pipe_valid=1 cycle one cycle later; i_step held high SHALL produce no further valid cycles.
REQ-013 o_cycle_count SHALL increment by 1 in every cycle with o_pipe_valid=1 and saturate at all-ones.
REQ-014 RUN->HALT on i_halt=1, or when a valid cycle brings o_cycle_count to i_max_cycles (i_max_cycles!=0).
REQ-015 A valid cycle coinciding with a halt condition SHALL be counted; o_pipe_valid SHALL be 0 from the cycle after.
REQ-016 HALT: o_done=1, o_pipe_valid=0, o_pipe_reset=0, o_cycle_count frozen; i_start=1 SHALL move to PRST.
REQ-017 i_start SHALL be ignored in PRST and RUN; i_halt SHALL be ignored outside RUN.
REQ-018 i_max_cycles SHALL be sampled continuously; a value already <= o_cycle_count SHALL halt on the next valid cycle.

Reset
REQ-019 i_reset=1 SHALL asynchronously force IDLE, o_pipe_reset=0, o_pipe_valid=0, o_cycle_count=0, o_done=0, phase counter 0, step edge detector 0.
REQ-020 Reset asserted mid-run SHALL abort the run immediately; after release the block SHALL wait for i_start.

Structure
REQ-021 State encodings and i_mode codes SHALL be localparams in the shared pipeline definitions header, reused by benches.
REQ-022 Throttle phase generation SHALL be one sub-module, pipeline_throttle_gen, with its own clock, reset, enable, divisor and strobe output.

Verification
REQ-023 RESET_CYCLES=2, mode RUN, i_start pulse at edge 5 -> o_pipe_reset high cycles 6-7, o_pipe_valid high from cycle 8, o_cycle_count=10 at cycle 18.
REQ-024 Mode THROTTLE, i_throttle=3 -> o_pipe_valid pattern 1000 repeating; change to i_throttle=0 mid-run -> valid every cycle from the next cycle.
REQ-025 Mode STEP, i_step pulsed 3 times and held high 5 cycles once -> exactly 4 valid cycles, o_cycle_count=4.
REQ-026 i_max_cycles=7, mode RUN -> exactly 7 valid cycles, o_done=1, o_state=11; i_start -> new PRST, count cleared.
REQ-027 i_halt asserted during a valid cycle -> that cycle counted, no valid afterwards; i_reset mid-RUN -> all outputs 0 in the same cycle, o_state=00.
